// File: rtl/jpeg_idct_xpose_buf_if.sv
// Write (row-pass) and read (column-pass) signals of the IDCT transpose buffer.
// slave = the buffer, master = the row/column pass driving it.
interface jpeg_idct_xpose_buf_if;
  logic        wr_en;
  logic [2:0]  wr_page;
  logic [1:0]  wr_count;
  logic [31:0] wr_data0;
  logic [31:0] wr_data1;
  logic        wr_ready;
  logic        overflow;
  logic        DataInEnable;
  logic        DataInRead;
  logic [4:0]  DataInAddress;
  logic [15:0] DataInA;
  logic [15:0] DataInB;

  modport slave (
    input  wr_en, wr_page, wr_count, wr_data0, wr_data1, DataInRead, DataInAddress,
    output wr_ready, overflow, DataInEnable, DataInA, DataInB
  );

  modport master (
    output wr_en, wr_page, wr_count, wr_data0, wr_data1, DataInRead, DataInAddress,
    input  wr_ready, overflow, DataInEnable, DataInA, DataInB
  );
endinterface

// File: rtl/jpeg_idct_xpose_buf.sv
// Ping-pong 8x8 transpose buffer between IDCT row and column passes; JPEG_XPOSE_SAT_EN enables clamping.
// Latency: block readable the cycle after beat (7,3); read data 1 cycle after DataInRead.
// Backpressure: wr_ready drops while the write bank is full; beats sent anyway are dropped and set overflow.
module jpeg_idct_xpose_buf #(
  parameter int SHIFT = 8
) (
  input logic                  clk,
  input logic                  rst,
  jpeg_idct_xpose_buf_if.slave bus
);

  localparam logic signed [32:0] RND = 33'sd1 <<< (SHIFT - 1);

  function automatic logic [15:0] narrow(input logic [31:0] v);
    logic signed [32:0] t;
    t = ($signed({v[31], v}) + RND) >>> SHIFT;
`ifdef JPEG_XPOSE_SAT_EN
    if (t > 33'sd32767)  return 16'h7fff;
    if (t < -33'sd32768) return 16'h8000;
`endif
    return t[15:0];
  endfunction

  logic [15:0] mem [0:127];

  logic [1:0] full, full_nx;
  logic       wbank, rbank, wbank_nx, rbank_nx;
  logic       wr_acc, wr_done, rd_rel;
  logic [2:0] rd_col, row_a, row_b;

  assign wr_acc  = bus.wr_en && bus.wr_ready;
  assign wr_done = wr_acc && (bus.wr_page == 3'd7) && (bus.wr_count == 2'd3);
  assign rd_rel  = bus.DataInRead && (bus.DataInAddress == 5'd31) && full[rbank];
  assign rd_col  = bus.DataInAddress[4:2];

  assign bus.DataInEnable = full[rbank];

  // A completing write and a releasing read always target different banks.
  always_comb begin
    full_nx  = full;
    wbank_nx = wbank;
    rbank_nx = rbank;
    if (rd_rel) begin
      full_nx[rbank] = 1'b0;
      rbank_nx       = ~rbank;
    end
    if (wr_done) begin
      full_nx[wbank] = 1'b1;
      wbank_nx       = ~wbank;
    end
  end

  // Column-pass butterfly ordering of the eight rows of one column.
  always_comb begin
    row_a = 3'd0;
    row_b = 3'd4;
    case (bus.DataInAddress[1:0])
      2'd0: begin row_a = 3'd0; row_b = 3'd4; end
      2'd1: begin row_a = 3'd2; row_b = 3'd6; end
      2'd2: begin row_a = 3'd1; row_b = 3'd7; end
      default: begin row_a = 3'd5; row_b = 3'd3; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full         <= 2'b00;
      wbank        <= 1'b0;
      rbank        <= 1'b0;
      bus.wr_ready <= 1'b1;
      bus.overflow <= 1'b0;
      bus.DataInA  <= 16'd0;
      bus.DataInB  <= 16'd0;
    end else begin
      full         <= full_nx;
      wbank        <= wbank_nx;
      rbank        <= rbank_nx;
      bus.wr_ready <= !full_nx[wbank_nx];
      if (bus.wr_en && !bus.wr_ready)
        bus.overflow <= 1'b1;
      if (bus.DataInRead) begin
        bus.DataInA <= mem[{rbank, row_a, rd_col}];
        bus.DataInB <= mem[{rbank, row_b, rd_col}];
      end
    end
  end

  // Column c and its mirror 7-c land in the low and high column halves.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[{wbank, bus.wr_page, 1'b0, bus.wr_count}]  <= narrow(bus.wr_data0);
      mem[{wbank, bus.wr_page, 1'b1, ~bus.wr_count}] <= narrow(bus.wr_data1);
    end
  end

endmodule
